// File: rtl/vga_pkg.sv
// Shared helpers for the programmable VGA timing generator: axis region
// arithmetic, a width helper and the colour-bar palette.
package vga_pkg;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
    logic fe;
  } vga_ctl_t;

  function automatic int unsigned vga_clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int sync_first(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int sync_last(input int active, input int fp, input int sync);
    return active + fp + sync - 1;
  endfunction

  // {r,g,b} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black
  function automatic logic [2:0] bar_colour(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = 3'b111;
      3'd1:    c = 3'b110;
      3'd2:    c = 3'b011;
      3'd3:    c = 3'b010;
      3'd4:    c = 3'b101;
      3'd5:    c = 3'b100;
      3'd6:    c = 3'b001;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis: position counter with wrap, plus active/sync region decode.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int W      = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         active,
  output logic         sync
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_LAST   = W'(ACTIVE - 1);
  localparam logic [W-1:0] SYNC_FIRST = W'(sync_first(ACTIVE, FP));
  localparam logic [W-1:0] SYNC_LAST  = W'(sync_last(ACTIVE, FP, SYNC));

  assign wrap   = inc && (cnt == LAST);
  assign active = (cnt <= ACT_LAST);
  assign sync   = (cnt >= SYNC_FIRST) && (cnt <= SYNC_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA timing generator with pixel pre-fetch and output realignment.
// Optional colour-bar source when VGA_TESTPAT_EN is defined.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int RD_LAT   = 2,
  parameter int COLOR_W  = 4,
  parameter int FRAME_W  = 16
) (
  input  logic                           vga_clk,
  input  logic                           rst_n,
  input  logic                           gen_en,
  output logic                           req_valid,
  output logic [vga_clog2(H_ACTIVE)-1:0] req_x,
  output logic [vga_clog2(V_ACTIVE)-1:0] req_y,
  input  logic [COLOR_W-1:0]             pix_r,
  input  logic [COLOR_W-1:0]             pix_g,
  input  logic [COLOR_W-1:0]             pix_b,
  input  logic                           test_mode,
  output logic                           hsync,
  output logic                           vsync,
  output logic                           de,
  output logic [3*COLOR_W-1:0]           rgb,
  output logic                           frame_start,
  output logic                           frame_end,
  output logic [FRAME_W-1:0]             frame_cnt
);

  localparam int HW = vga_clog2(axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int VW = vga_clog2(axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam int XW = vga_clog2(H_ACTIVE);
  localparam int YW = vga_clog2(V_ACTIVE);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic h_wrap, h_act, h_sync;
  logic v_wrap_unused, v_act, v_sync;

  vga_axis_cnt #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(HW)) u_h_cnt (
    .clk(vga_clk), .rst_n(rst_n), .clr(!gen_en), .inc(gen_en),
    .cnt(h_cnt), .wrap(h_wrap), .active(h_act), .sync(h_sync)
  );

  vga_axis_cnt #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(VW)) u_v_cnt (
    .clk(vga_clk), .rst_n(rst_n), .clr(!gen_en), .inc(h_wrap),
    .cnt(v_cnt), .wrap(v_wrap_unused), .active(v_act), .sync(v_sync)
  );

  logic at_first, at_last, pos_act;
  assign pos_act  = h_act && v_act;
  assign at_first = (h_cnt == '0) && (v_cnt == '0);
  assign at_last  = (h_cnt == HW'(H_ACTIVE - 1)) && (v_cnt == VW'(V_ACTIVE - 1));

  // s0 is the request stage; pipe[RD_LAT] lines up with the returned pixel
  vga_ctl_t s0;
  vga_ctl_t pipe [RD_LAT+1];

  always_ff @(posedge vga_clk) begin
    if (!rst_n || !gen_en) begin
      s0    <= '0;
      req_x <= '0;
      req_y <= '0;
      for (int i = 0; i <= RD_LAT; i++) pipe[i] <= '0;
    end else begin
      s0    <= '{hs: h_sync, vs: v_sync, de: pos_act, fs: at_first, fe: at_last};
      req_x <= pos_act ? h_cnt[XW-1:0] : '0;
      req_y <= pos_act ? v_cnt[YW-1:0] : '0;
      pipe[0] <= s0;
      for (int i = 1; i <= RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  logic [3*COLOR_W-1:0] pix_sel;

`ifdef VGA_TESTPAT_EN
  logic [2:0] bar0;
  logic [2:0] bar_d [RD_LAT];
  logic [2:0] bar_c;

  always_ff @(posedge vga_clk) begin
    if (!rst_n || !gen_en) begin
      bar0 <= '0;
      for (int i = 0; i < RD_LAT; i++) bar_d[i] <= '0;
    end else begin
      bar0     <= 3'((int'(h_cnt) * 8) / H_ACTIVE);
      bar_d[0] <= bar0;
      for (int i = 1; i < RD_LAT; i++) bar_d[i] <= bar_d[i-1];
    end
  end

  assign bar_c   = bar_colour(bar_d[RD_LAT-1]);
  assign pix_sel = test_mode ? {{COLOR_W{bar_c[2]}}, {COLOR_W{bar_c[1]}}, {COLOR_W{bar_c[0]}}}
                             : {pix_r, pix_g, pix_b};
`else
  logic test_mode_unused;
  assign test_mode_unused = test_mode;
  assign pix_sel = {pix_r, pix_g, pix_b};
`endif

  // rgb and frame_cnt update on the same edge that loads pipe[RD_LAT]
  always_ff @(posedge vga_clk) begin
    if (!rst_n || !gen_en) begin
      rgb <= '0;
    end else begin
      rgb <= pipe[RD_LAT-1].de ? pix_sel : '0;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (gen_en && pipe[RD_LAT-1].fe) begin
      frame_cnt <= frame_cnt + FRAME_W'(1);
    end
  end

  assign req_valid   = s0.de;
  assign de          = pipe[RD_LAT].de;
  assign hsync       = HS_POL ? pipe[RD_LAT].hs : ~pipe[RD_LAT].hs;
  assign vsync       = VS_POL ? pipe[RD_LAT].vs : ~pipe[RD_LAT].vs;
  assign frame_start = pipe[RD_LAT].fs;
  assign frame_end   = pipe[RD_LAT].fe;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 14x8 raster (H 8/2/3/1, V 4/1/2/1, RD_LAT=2).
// With VGA_TESTPAT_EN a second full-size instance exercises the colour bars.
module tb_vga_timing_gen;

  logic clk;
  logic rst_n, gen_en, test_mode;
  logic req_valid;
  logic [2:0] req_x;
  logic [1:0] req_y;
  logic [11:0] pix_v;
  logic hsync, vsync, de, frame_start, frame_end;
  logic [11:0] rgb;
  logic [1:0] frame_cnt;

  logic [11:0] hist_a, hist_b;
  int errors = 0;
  int checks = 0;
  int cur_n = 0;
  int fs_seen, fe_seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(2), .COLOR_W(4), .FRAME_W(2)
  ) dut (
    .vga_clk(clk), .rst_n(rst_n), .gen_en(gen_en),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .pix_r(pix_v[11:8]), .pix_g(pix_v[7:4]), .pix_b(pix_v[3:0]),
    .test_mode(test_mode),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
    .frame_start(frame_start), .frame_end(frame_end), .frame_cnt(frame_cnt)
  );

`ifdef VGA_TESTPAT_EN
  logic rst2_n, en2;
  logic req2_valid, hs2, vs2, de2, fs2, fe2;
  logic [9:0] req2_x;
  logic [8:0] req2_y;
  logic [11:0] rgb2;
  logic [15:0] fcnt2;

  vga_timing_gen dut2 (
    .vga_clk(clk), .rst_n(rst2_n), .gen_en(en2),
    .req_valid(req2_valid), .req_x(req2_x), .req_y(req2_y),
    .pix_r(4'h1), .pix_g(4'h2), .pix_b(4'h3),
    .test_mode(1'b1),
    .hsync(hs2), .vsync(vs2), .de(de2), .rgb(rgb2),
    .frame_start(fs2), .frame_end(fe2), .frame_cnt(fcnt2)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s n=%0d got=%0h exp=%0h", tag, cur_n, got, exp);
    end
  endtask

  // Advance one clock; the pixel source returns {x,y,5} two cycles after each request.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    pix_v  = hist_b;
    hist_b = hist_a;
    hist_a = req_valid ? {1'b0, req_x, 2'b00, req_y, 4'h5} : 12'hBAD;
  endtask

  task automatic check_idle(input logic [1:0] fexp);
    chk("idle_req_valid", req_valid, 0);
    chk("idle_req_x", req_x, 0);
    chk("idle_req_y", req_y, 0);
    chk("idle_de", de, 0);
    chk("idle_rgb", rgb, 0);
    chk("idle_hsync", hsync, 1);
    chk("idle_vsync", vsync, 1);
    chk("idle_frame_start", frame_start, 0);
    chk("idle_frame_end", frame_end, 0);
    chk("idle_frame_cnt", frame_cnt, fexp);
  endtask

  // n = cycles since counters left (0,0); request shows position n-1, outputs n-4.
  task automatic check_cycle(input int n, input int fbase);
    int p, q, h, v, nfe;
    logic ev, ed, ehs, evs, efs, efe;
    logic [11:0] ergb;
    cur_n = n;
    p  = n - 1;
    h  = p % 14;
    v  = (p / 14) % 8;
    ev = (h < 8) && (v < 4);
    chk("req_valid", req_valid, ev);
    chk("req_x", req_x, ev ? h : 0);
    chk("req_y", req_y, ev ? v : 0);
    q = n - 4;
    ed = 0; ehs = 1; evs = 1; efs = 0; efe = 0; ergb = '0; nfe = 0;
    if (q >= 0) begin
      h   = q % 14;
      v   = (q / 14) % 8;
      ed  = (h < 8) && (v < 4);
      ehs = !((h >= 10) && (h <= 12));
      evs = !((v >= 5) && (v <= 6));
      efs = (q % 112) == 0;
      efe = (q % 112) == 49;
      if (ed) ergb = {4'(h), 4'(v), 4'h5};
      nfe = (q >= 49) ? ((q - 49) / 112 + 1) : 0;
    end
    chk("de", de, ed);
    chk("hsync", hsync, ehs);
    chk("vsync", vsync, evs);
    chk("rgb", rgb, ergb);
    chk("frame_start", frame_start, efs);
    chk("frame_end", frame_end, efe);
    chk("frame_cnt", frame_cnt, (fbase + nfe) % 4);
    if (frame_start === 1'b1) fs_seen++;
    if (frame_end === 1'b1) fe_seen++;
  endtask

  initial begin
    rst_n = 1'b0; gen_en = 1'b1; test_mode = 1'b0;
    pix_v = 12'hBAD; hist_a = 12'hBAD; hist_b = 12'hBAD;
`ifdef VGA_TESTPAT_EN
    rst2_n = 1'b0; en2 = 1'b0;
`endif
    // reset dominates gen_en
    repeat (3) step();
    check_idle(2'd0);
    rst_n = 1'b1; gen_en = 1'b0;
    repeat (2) step();
    check_idle(2'd0);
    gen_en = 1'b1;

    // three frames in progress, then drop gen_en at counter position (5,2) of frame 3
    fs_seen = 0; fe_seen = 0;
    for (int n = 1; n <= 257; n++) begin
      step();
      check_cycle(n, 0);
    end
    chk("ph1_fs_pulses", fs_seen, 3);
    chk("ph1_fe_pulses", fe_seen, 2);
    gen_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      cur_n = k;
      check_idle(2'd2);
    end

    // resume from (0,0); frame_cnt 2 -> 3 -> wraps to 0 -> 1
    gen_en = 1'b1;
    fs_seen = 0; fe_seen = 0;
    for (int n = 1; n <= 290; n++) begin
      step();
      check_cycle(n, 2);
    end
    chk("ph2_fs_pulses", fs_seen, 3);
    chk("ph2_fe_pulses", fe_seen, 3);

    // one-cycle reset mid-line at position (10,4)
    rst_n = 1'b0;
    step();
    cur_n = 0;
    check_idle(2'd0);
    rst_n = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      step();
      check_cycle(n, 0);
    end

`ifdef VGA_TESTPAT_EN
    rst2_n = 1'b1; en2 = 1'b1;
    for (int n = 1; n <= 643; n++) begin
      step();
      cur_n = n;
      case (n)
        4:   chk("bar_x0", rgb2, 12'hFFF);
        83:  chk("bar_x79", rgb2, 12'hFFF);
        84:  chk("bar_x80", rgb2, 12'hFF0);
        163: chk("bar_x159", rgb2, 12'hFF0);
        404: chk("bar_x400", rgb2, 12'hF00);
        564: chk("bar_x560", rgb2, 12'h000);
        643: begin
          chk("bar_x639", rgb2, 12'h000);
          chk("bar_de639", de2, 1);
        end
        default: ;
      endcase
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
